// File: rtl/oam_dma_arbiter_pkg.sv
// Shared constants and state type for the OAM DMA arbiter and its address decoder.
package oam_dma_arbiter_pkg;

    localparam logic [15:0] DMA_REG_ADDR       = 16'hFF46;
    localparam logic [15:0] HRAM_LO            = 16'hFF80;
    localparam logic [15:0] HRAM_HI            = 16'hFFFE;
    localparam logic [15:0] OAM_BASE           = 16'hFE00;
    localparam int          DMA_LENGTH_DEFAULT = 160;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_START    = 2'd1,
        ST_TRANSFER = 2'd2
    } dma_state_t;

endpackage

// File: rtl/oam_dma_arbiter_decode.sv
// CPU address decode: High RAM window and the DMA page register.
module hram_window_decode
    import oam_dma_arbiter_pkg::*;
(
    input  logic [15:0] address,
    output logic        is_hram,
    output logic        is_dma_reg
);

    assign is_hram    = (address >= HRAM_LO) && (address <= HRAM_HI);
    assign is_dma_reg = (address == DMA_REG_ADDR);

endmodule

// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine: copies one source page into OAM while restricting the CPU to High RAM.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
#(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int DMA_LENGTH      = DMA_LENGTH_DEFAULT
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [15:0] i_Cpu_Address,
    input  logic        i_Cpu_Bus_Enable,
    input  logic        i_Cpu_ReadWrite,
    input  logic [7:0]  i_Cpu_Data,
    output logic [7:0]  o_Cpu_Data,
    output logic        o_Cpu_Bus_Enable,
    output logic        o_Hram_Enable,
    output logic [15:0] o_Src_Address,
    output logic        o_Src_Read,
    input  logic [7:0]  i_Src_Data,
    output logic [7:0]  o_Oam_Address,
    output logic [7:0]  o_Oam_Data,
    output logic        o_Oam_Write,
    output logic        o_Dma_Active
);

    localparam logic [3:0] SUB_LAST = 4'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0] IDX_LAST = 8'(DMA_LENGTH - 1);

    dma_state_t state, state_n;
    logic [7:0] page,  page_n;
    logic [7:0] index, index_n;
    logic [3:0] sub,   sub_n;

    logic is_hram;
    logic is_dma_reg;
    logic dma_start;
    logic cpu_read;
    logic blocked;
    logic in_transfer;

    hram_window_decode u_decode (
        .address    (i_Cpu_Address),
        .is_hram    (is_hram),
        .is_dma_reg (is_dma_reg)
    );

    assign dma_start   = i_Cpu_Bus_Enable & i_Cpu_ReadWrite & is_dma_reg;
    assign cpu_read    = i_Cpu_Bus_Enable & ~i_Cpu_ReadWrite;
    assign in_transfer = (state == ST_TRANSFER);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state <= ST_IDLE;
            page  <= 8'h00;
            index <= 8'h00;
            sub   <= 4'h0;
        end else begin
            state <= state_n;
            page  <= page_n;
            index <= index_n;
            sub   <= sub_n;
        end
    end

    // The sub-counter times both the START wait and each byte slot of the transfer.
    always_comb begin
        state_n = state;
        page_n  = page;
        index_n = index;
        sub_n   = sub;
        if (dma_start) begin
            page_n  = i_Cpu_Data;
            index_n = 8'h00;
            sub_n   = 4'h0;
            state_n = ST_START;
        end else begin
            case (state)
                ST_START: begin
                    if (sub == SUB_LAST) begin
                        sub_n   = 4'h0;
                        index_n = 8'h00;
                        state_n = ST_TRANSFER;
                    end else begin
                        sub_n = sub + 4'd1;
                    end
                end
                ST_TRANSFER: begin
                    if (sub == SUB_LAST) begin
                        sub_n = 4'h0;
                        if (index == IDX_LAST) begin
                            index_n = 8'h00;
                            state_n = ST_IDLE;
                        end else begin
                            index_n = index + 8'd1;
                        end
                    end else begin
                        sub_n = sub + 4'd1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    assign o_Dma_Active  = in_transfer;
    assign o_Src_Read    = in_transfer;
    assign o_Src_Address = in_transfer ? {page, index} : 16'h0000;
    assign o_Oam_Address = in_transfer ? index : 8'h00;
    assign o_Oam_Data    = in_transfer ? i_Src_Data : 8'h00;
    assign o_Oam_Write   = in_transfer && (sub == SUB_LAST);
    assign o_Hram_Enable = is_hram;

    // The page register stays reachable during DMA so software can poll or restart it.
    assign blocked          = in_transfer & i_Cpu_Bus_Enable & ~is_hram & ~is_dma_reg;
    assign o_Cpu_Bus_Enable = blocked ? 1'b0 : i_Cpu_Bus_Enable;

    always_comb begin
        o_Cpu_Data = 8'h00;
        if (cpu_read && is_dma_reg) begin
            o_Cpu_Data = page;
        end else if (cpu_read && blocked) begin
            o_Cpu_Data = 8'hFF;
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: expected OAM writes queued at DMA start, checked on each write strobe.
module tb_oam_dma_arbiter;

    logic        i_Clk;
    logic        i_Rst;
    logic [15:0] i_Cpu_Address;
    logic        i_Cpu_Bus_Enable;
    logic        i_Cpu_ReadWrite;
    logic [7:0]  i_Cpu_Data;
    logic [7:0]  o_Cpu_Data;
    logic        o_Cpu_Bus_Enable;
    logic        o_Hram_Enable;
    logic [15:0] o_Src_Address;
    logic        o_Src_Read;
    logic [7:0]  i_Src_Data;
    logic [7:0]  o_Oam_Address;
    logic [7:0]  o_Oam_Data;
    logic        o_Oam_Write;
    logic        o_Dma_Active;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];

    oam_dma_arbiter #(
        .CYCLES_PER_BYTE (4),
        .DMA_LENGTH      (160)
    ) dut (
        .i_Clk            (i_Clk),
        .i_Rst            (i_Rst),
        .i_Cpu_Address    (i_Cpu_Address),
        .i_Cpu_Bus_Enable (i_Cpu_Bus_Enable),
        .i_Cpu_ReadWrite  (i_Cpu_ReadWrite),
        .i_Cpu_Data       (i_Cpu_Data),
        .o_Cpu_Data       (o_Cpu_Data),
        .o_Cpu_Bus_Enable (o_Cpu_Bus_Enable),
        .o_Hram_Enable    (o_Hram_Enable),
        .o_Src_Address    (o_Src_Address),
        .o_Src_Read       (o_Src_Read),
        .i_Src_Data       (i_Src_Data),
        .o_Oam_Address    (o_Oam_Address),
        .o_Oam_Data       (o_Oam_Data),
        .o_Oam_Write      (o_Oam_Write),
        .o_Dma_Active     (o_Dma_Active)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    assign i_Src_Data = src_byte(o_Src_Address);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_xfer(input logic [7:0] page, input int count);
        logic [7:0] idx;
        for (int i = 0; i < count; i++) begin
            idx = 8'(i);
            sb_q.push_back({page, idx, idx, src_byte({page, idx})});
        end
    endtask

    task automatic cpu_set(input logic [15:0] a, input logic en, input logic rw, input logic [7:0] d);
        i_Cpu_Address    = a;
        i_Cpu_Bus_Enable = en;
        i_Cpu_ReadWrite  = rw;
        i_Cpu_Data       = d;
        #1;
    endtask

    task automatic cpu_idle();
        i_Cpu_Address    = 16'h0000;
        i_Cpu_Bus_Enable = 1'b0;
        i_Cpu_ReadWrite  = 1'b0;
        i_Cpu_Data       = 8'h00;
    endtask

    task automatic dma_start(input logic [7:0] page);
        cpu_set(16'hFF46, 1'b1, 1'b1, page);
        @(posedge i_Clk);
        #1;
        cpu_idle();
    endtask

    task automatic wait_index(input logic [7:0] idx, input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            if (o_Dma_Active && o_Oam_Address == idx) break;
            @(posedge i_Clk);
            #1;
        end
        chk("wait_index_timeout", 32'(k < limit), 32'd1);
    endtask

    // Scoreboard: every OAM write strobe consumes one expected entry.
    always @(negedge i_Clk) begin
        logic [31:0] e;
        if (o_Oam_Write) begin
            if (sb_q.size() == 0) begin
                chk("oam_unexpected", 32'(o_Oam_Address), 32'hFFFF);
            end else begin
                e = sb_q.pop_front();
                chk("src_addr", 32'(o_Src_Address), 32'(e[31:16]));
                chk("oam_addr", 32'(o_Oam_Address), 32'(e[15:8]));
                chk("oam_data", 32'(o_Oam_Data), 32'(e[7:0]));
                chk("src_read", 32'(o_Src_Read), 32'd1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int first_act;

        i_Rst = 1'b1;
        cpu_idle();
        repeat (2) @(posedge i_Clk);
        #1;
        chk("rst_active", 32'(o_Dma_Active), 32'd0);
        chk("rst_oam_wr", 32'(o_Oam_Write), 32'd0);
        chk("rst_src_rd", 32'(o_Src_Read), 32'd0);
        chk("rst_src_addr", 32'(o_Src_Address), 32'd0);
        chk("rst_oam_addr", 32'(o_Oam_Address), 32'd0);
        i_Rst = 1'b0;
        @(posedge i_Clk);
        #1;
        cpu_set(16'hFF46, 1'b1, 1'b0, 8'h00);
        chk("rst_page", 32'(o_Cpu_Data), 32'h00);

        // Idle: CPU passes through, HRAM window edges.
        cpu_set(16'h8000, 1'b1, 1'b0, 8'h00);
        chk("idle_bus_en", 32'(o_Cpu_Bus_Enable), 32'd1);
        chk("idle_data", 32'(o_Cpu_Data), 32'h00);
        chk("idle_hram_8000", 32'(o_Hram_Enable), 32'd0);
        cpu_set(16'hFF80, 1'b1, 1'b0, 8'h00);
        chk("hram_ff80", 32'(o_Hram_Enable), 32'd1);
        cpu_set(16'hFFFE, 1'b1, 1'b0, 8'h00);
        chk("hram_fffe", 32'(o_Hram_Enable), 32'd1);
        cpu_set(16'hFFFF, 1'b1, 1'b0, 8'h00);
        chk("hram_ffff", 32'(o_Hram_Enable), 32'd0);
        cpu_set(16'hFF7F, 1'b1, 1'b0, 8'h00);
        chk("hram_ff7f", 32'(o_Hram_Enable), 32'd0);
        cpu_idle();
        @(posedge i_Clk);
        #1;

        // Full transfer from page 0xC1 with CPU arbitration checks mid-way.
        push_xfer(8'hC1, 160);
        dma_start(8'hC1);
        chk("start_active", 32'(o_Dma_Active), 32'd0);
        first_act = 0;
        for (n = 1; n <= 800; n++) begin
            @(posedge i_Clk);
            #1;
            if (o_Dma_Active && first_act == 0) first_act = n;
            if (n == 100) begin
                cpu_set(16'h8000, 1'b1, 1'b0, 8'h00);
                chk("blk_read_data", 32'(o_Cpu_Data), 32'hFF);
                chk("blk_read_en", 32'(o_Cpu_Bus_Enable), 32'd0);
                cpu_set(16'hFF90, 1'b1, 1'b0, 8'h00);
                chk("hram_read_hram", 32'(o_Hram_Enable), 32'd1);
                chk("hram_read_en", 32'(o_Cpu_Bus_Enable), 32'd1);
                cpu_set(16'hFF46, 1'b1, 1'b0, 8'h00);
                chk("dma_reg_read", 32'(o_Cpu_Data), 32'hC1);
                cpu_set(16'hFFFF, 1'b1, 1'b1, 8'h55);
                chk("blk_write_en", 32'(o_Cpu_Bus_Enable), 32'd0);
                cpu_idle();
            end
            if (first_act != 0 && !o_Dma_Active) break;
        end
        chk("start_len", 32'(first_act), 32'd4);
        chk("xfer_total", 32'(n), 32'd644);
        chk("q_empty_full", 32'(sb_q.size()), 32'd0);

        // Restart at index 50 with page 0xD0.
        push_xfer(8'hC1, 50);
        dma_start(8'hC1);
        wait_index(8'd50, 400);
        chk("q_empty_pre_restart", 32'(sb_q.size()), 32'd0);
        push_xfer(8'hD0, 160);
        dma_start(8'hD0);
        for (int k = 0; k < 4; k++) begin
            chk("restart_inactive", 32'(o_Dma_Active), 32'd0);
            chk("restart_src_rd", 32'(o_Src_Read), 32'd0);
            chk("restart_src_addr", 32'(o_Src_Address), 32'd0);
            @(posedge i_Clk);
            #1;
        end
        chk("restart_active", 32'(o_Dma_Active), 32'd1);
        chk("restart_src0", 32'(o_Src_Address), 32'hD000);
        chk("restart_idx0", 32'(o_Oam_Address), 32'd0);
        for (n = 4; n < 800 && o_Dma_Active; n++) begin
            @(posedge i_Clk);
            #1;
        end
        chk("restart_total", 32'(n), 32'd644);
        chk("q_empty_restart", 32'(sb_q.size()), 32'd0);

        // Reset at index 80 aborts the transfer immediately.
        push_xfer(8'h77, 80);
        dma_start(8'h77);
        wait_index(8'd80, 400);
        chk("q_empty_pre_rst", 32'(sb_q.size()), 32'd0);
        i_Rst = 1'b1;
        #1;
        chk("midrst_active", 32'(o_Dma_Active), 32'd0);
        chk("midrst_oam_wr", 32'(o_Oam_Write), 32'd0);
        chk("midrst_src_rd", 32'(o_Src_Read), 32'd0);
        repeat (2) @(posedge i_Clk);
        #1;
        i_Rst = 1'b0;
        repeat (20) @(posedge i_Clk);
        #1;
        chk("post_rst_active", 32'(o_Dma_Active), 32'd0);
        cpu_set(16'hFF46, 1'b1, 1'b0, 8'h00);
        chk("post_rst_page", 32'(o_Cpu_Data), 32'h00);
        cpu_idle();
        chk("q_empty_rst", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
